// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit. Radix-2 shift-add multiply
//            and restoring divide on operand magnitudes. A sign fix-up is
//            applied at the end. Divide-by-zero and signed overflow take a
//            short path straight to DONE.
// Ports    : clk, rst_n (async, active-low), flush (sync abort)
//            in_valid/in_ready + MulDivOp/SrcA/SrcB  : request channel
//            out_valid/out_ready + Result            : response channel
//            busy                                    : state != IDLE
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            MulDivOp,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  busy
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  logic [1:0]    state_q, state_d;
  logic [W-1:0]  hi_q, hi_d;     // product high half / partial remainder
  logic [W-1:0]  lo_q, lo_d;     // product low half (multiplier) / dividend->quotient
  logic [W-1:0]  b_q, b_d;       // multiplicand / divisor magnitude
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    op_q, op_d;
  logic          neg_q, neg_d;
  logic [W-1:0]  res_q, res_d;

  // Request decode
  logic          w_accept;
  logic          w_is_div;
  logic          w_a_signed, w_b_signed;
  logic          w_sa, w_sb;
  logic [W-1:0]  w_mag_a, w_mag_b;
  logic          w_b_zero, w_ovf, w_special;
  logic [W-1:0]  w_special_res;
  logic          w_neg;

  // Iteration / fix-up datapath
  logic [W:0]    w_mul_sum;
  logic [W:0]    w_div_shift;
  logic [W:0]    w_div_diff;
  logic [2*W-1:0] w_prod_fix;
  logic [W-1:0]  w_quo_fix, w_rem_fix;

  assign w_accept = (state_q == S_IDLE) && in_valid && !flush;
  assign w_is_div = MulDivOp[2];

  // Signed A: MUL, MULH, MULHSU, DIV, REM. Signed B: MUL, MULH, DIV, REM.
  assign w_a_signed = w_is_div ? !MulDivOp[0] : (MulDivOp != 3'b011);
  assign w_b_signed = w_is_div ? !MulDivOp[0] : !MulDivOp[1];
  assign w_sa = w_a_signed & SrcA[W-1];
  assign w_sb = w_b_signed & SrcB[W-1];
  assign w_mag_a = w_sa ? -SrcA : SrcA;
  assign w_mag_b = w_sb ? -SrcB : SrcB;

  // Remainder follows the dividend's sign; everything else is sA^sB.
  assign w_neg = (w_is_div && MulDivOp[1]) ? w_sa : (w_sa ^ w_sb);

  assign w_b_zero = (SrcB == '0);
  assign w_ovf    = w_is_div && !MulDivOp[0]
                 && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == {W{1'b1}});
  assign w_special = w_is_div && (w_b_zero || w_ovf);
  // Overflow case: quotient is the dividend itself, remainder is zero.
  assign w_special_res = w_b_zero ? (MulDivOp[1] ? SrcA : {W{1'b1}})
                                  : (MulDivOp[1] ? '0   : SrcA);

  assign w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign w_div_shift = {hi_q, lo_q[W-1]};
  assign w_div_diff  = w_div_shift - {1'b0, b_q};
  assign w_prod_fix  = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign w_quo_fix   = neg_q ? -lo_q : lo_q;
  assign w_rem_fix   = neg_q ? -hi_q : hi_q;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state (flush overrides every transition)
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (in_valid) state_d = w_special ? S_DONE : S_CALC;
        S_CALC: if (cnt_q == '0) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: if (out_ready) state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state_q == S_IDLE);
    busy      = (state_q != S_IDLE);
    out_valid = (state_q == S_DONE);
    Result    = res_q;
  end

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    b_d   = b_q;
    cnt_d = cnt_q;
    op_d  = op_q;
    neg_d = neg_q;
    res_d = res_q;

    if (w_accept) begin
      op_d  = MulDivOp;
      neg_d = w_neg;
      cnt_d = CNT_LAST;
      hi_d  = '0;
      lo_d  = w_mag_a;
      b_d   = w_mag_b;
      if (w_special) res_d = w_special_res;
    end else if (state_q == S_CALC) begin
      cnt_d = cnt_q - 1'b1;
      if (!op_q[2]) begin
        // Add carry-out becomes the new top bit as the product shifts right.
        {hi_d, lo_d} = {w_mul_sum, lo_q[W-1:1]};
      end else begin
        // Restoring step: keep the shifted remainder when the trial goes negative.
        hi_d = w_div_diff[W] ? w_div_shift[W-1:0] : w_div_diff[W-1:0];
        lo_d = {lo_q[W-2:0], ~w_div_diff[W]};
      end
    end else if ((state_q == S_FIX) && !flush) begin
      case (op_q)
        3'b000:                 res_d = w_prod_fix[W-1:0];
        3'b001, 3'b010, 3'b011: res_d = w_prod_fix[2*W-1:W];
        3'b100, 3'b101:         res_d = w_quo_fix;
        default:                res_d = w_rem_fix;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      op_q  <= '0;
      neg_q <= 1'b0;
      res_q <= '0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      b_q   <= b_d;
      cnt_q <= cnt_d;
      op_q  <= op_d;
      neg_q <= neg_d;
      res_q <= res_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_unit
// Purpose  : Self-checking bench for muldiv_unit: table of directed vectors
//            with hand-computed results and latencies, plus sequences for
//            backpressure, flush and asynchronous reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  MulDivOp;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Result;
  logic        busy;

  muldiv_unit #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .MulDivOp  (MulDivOp),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Result    (Result),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;   // edges after the accept edge until out_valid is seen
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Present one request; returns just after the accept edge. Inputs are
  // scrambled afterwards so a design that re-reads them gets caught.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    MulDivOp = op;
    SrcA     = a;
    SrcB     = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    MulDivOp = ~op;
    SrcA     = 32'hDEADBEEF;
    SrcB     = 32'h0BADF00D;
  endtask

  // Waits for out_valid, bounded. stall_ok stays 1 while busy=1/in_ready=0
  // held on every sampled cycle before the result appeared.
  task automatic wait_valid(output int edges, output logic stall_ok);
    edges    = 0;
    stall_ok = 1'b1;
    while (!out_valid && edges < 100) begin
      if (!busy || in_ready) stall_ok = 1'b0;
      @(posedge clk);
      #1;
      edges++;
    end
    if (!out_valid) edges = -1;
  endtask

  initial begin
    int   lat;
    logic sok;
    int   viol;

    vecs[0]  = '{3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};  // MUL 7*-3
    vecs[1]  = '{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};  // MULH
    vecs[2]  = '{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};  // MULHSU
    vecs[3]  = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};  // MULHU
    vecs[4]  = '{3'b000, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780, 33};  // MUL low
    vecs[5]  = '{3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33};  // MULH -1*-1
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 33};  // DIV -7/2
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 33};  // REM -7%2
    vecs[8]  = '{3'b101, 32'd100,       32'd7,         32'd14,        33};  // DIVU
    vecs[9]  = '{3'b111, 32'd100,       32'd7,         32'd2,         33};  // REMU
    vecs[10] = '{3'b100, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 33};  // DIV 7/-2
    vecs[11] = '{3'b110, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 33};  // REM 7%-2
    vecs[12] = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 33};  // DIVU max/1
    vecs[13] = '{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 0};   // DIVU /0
    vecs[14] = '{3'b111, 32'd5,         32'd0,         32'd5,         0};   // REMU /0
    vecs[15] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0};   // DIV ovf
    vecs[16] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0};   // REM ovf
    vecs[17] = '{3'b110, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 0};   // REM -5/0

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    MulDivOp = 3'b000; SrcA = '0; SrcB = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset in_ready",  {31'd0, in_ready},  32'd1);
    check("reset busy",      {31'd0, busy},      32'd0);
    check("reset out_valid", {31'd0, out_valid}, 32'd0);
    check("reset Result",    Result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    for (int i = 0; i < NV; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_valid(lat, sok);
      check($sformatf("vec%0d result", i), Result, vecs[i].exp);
      check($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      if (i == 0) check("vec0 stall busy/in_ready", {31'd0, sok}, 32'd1);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d back to idle", i), {31'd0, in_ready}, 32'd1);
    end

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(3'b101, 32'd100, 32'd7);
    wait_valid(lat, sok);
    check("bp result", Result, 32'd14);
    viol = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || Result !== 32'd14) viol++;
    end
    check("bp hold violations", viol, 0);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release out_valid", {31'd0, out_valid}, 32'd0);
    check("bp release in_ready",  {31'd0, in_ready},  32'd1);
    issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("bp next accepted", {31'd0, busy}, 32'd1);
    wait_valid(lat, sok);
    check("bp next result", Result, 32'hFFFF_FFFE);
    @(posedge clk);

    // Flush in CALC cycle 15
    issue(3'b000, 32'h7, 32'hFFFF_FFFD);
    repeat (14) @(posedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush in_ready",  {31'd0, in_ready},  32'd1);
    check("flush busy",      {31'd0, busy},      32'd0);
    check("flush out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    viol = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) viol++;
    end
    check("flush no late result", viol, 0);

    // Flush beats a same-cycle accept
    @(negedge clk);
    flush = 1'b1; in_valid = 1'b1; MulDivOp = 3'b101; SrcA = 32'd9; SrcB = 32'd3;
    @(posedge clk);
    #1;
    check("flush vs accept busy", {31'd0, busy}, 32'd0);
    flush = 1'b0; in_valid = 1'b0;

    // Flush drops a pending result in DONE
    out_ready = 1'b0;
    issue(3'b101, 32'd5, 32'd0);
    check("flush-done pre valid", {31'd0, out_valid}, 32'd1);
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    check("flush-done out_valid", {31'd0, out_valid}, 32'd0);
    flush = 1'b0;
    out_ready = 1'b1;

    // Asynchronous reset mid-CALC
    issue(3'b101, 32'd100, 32'd7);
    repeat (10) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst in_ready",  {31'd0, in_ready},  32'd1);
    check("arst busy",      {31'd0, busy},      32'd0);
    check("arst out_valid", {31'd0, out_valid}, 32'd0);
    check("arst Result",    Result,             32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    issue(3'b111, 32'd100, 32'd7);
    wait_valid(lat, sok);
    check("post-reset result",  Result, 32'd2);
    check("post-reset latency", lat,    33);
    @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the bench always ends on its own.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
